// File: rtl/multicycle_ctrl.sv
// Multicycle processor control unit: a Moore FSM that sequences the shared
// datapath through fetch/decode/execute. It bounds the time spent waiting on
// memory and counts retired instructions with saturation.
module multicycle_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic             ALUSrcA,
    output logic             RegWrite,
    output logic             RegDst,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       state,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_HALT   = 4'd12,
        S_ERROR  = 4'd13
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [5:0]        op_q, op_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              inWaitState;
    logic              waitExpired;
    logic              retiring;

    // Next-state logic: decode, memory-wait timeout and retired-instruction counting
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wait_d      = '0;
        count_d     = count_q;
        inWaitState = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        waitExpired = inWaitState && !mem_ready && (wait_q == WAIT_LIMIT);
        retiring    = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (waitExpired)    state_d = S_ERROR;
                else if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_ADDI:       state_d = S_ADDIEX;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_HALT:       state_d = S_HALT;
                    default:       state_d = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                if (op_q == OP_LW)      state_d = S_MEMRD;
                else if (op_q == OP_SW) state_d = S_MEMWR;
                else                    state_d = S_ERROR;
            end
            S_MEMRD: begin
                if (waitExpired)    state_d = S_ERROR;
                else if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                if (waitExpired)    state_d = S_ERROR;
                else if (mem_ready) state_d = S_FETCH;
            end
            S_MEMWB:  state_d = S_FETCH;
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_ERROR;
        endcase

        if (inWaitState && !mem_ready && (state_d == state_q)) begin
            wait_d = wait_q + WAIT_W'(1);
        end

        retiring = (state_d == S_FETCH) && (state_q != S_FETCH);
        if (retiring && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // State, wait counter, latched opcode and retired count, with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            op_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            op_q    <= op_d;
            count_q <= count_d;
        end
    end

    // Moore outputs per state, all forced low while reset is held
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        halted      = 1'b0;
        err         = 1'b0;
        instr_count = count_q;
        state       = state_q;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = mem_ready;
                IRWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_HALT:  halted = 1'b1;
            S_ERROR: err    = 1'b1;
            default: ;
        endcase

        if (!rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            MemtoReg    = 1'b0;
            IRWrite     = 1'b0;
            ALUSrcA     = 1'b0;
            RegWrite    = 1'b0;
            RegDst      = 1'b0;
            PCSource    = 2'b00;
            ALUOp       = 2'b00;
            ALUSrcB     = 2'b00;
            halted      = 1'b0;
            err         = 1'b0;
            instr_count = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: table-driven instruction sequences plus
// hand-written memory-timeout and mid-wait reset sequences. A second instance
// with a 2-bit retired counter rides along on the same stimulus to show saturation.
module tb_multicycle_ctrl;

    // Control word packing: {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
    // IRWrite, ALUSrcA, RegWrite, RegDst, PCSource[1:0], ALUOp[1:0], ALUSrcB[1:0]}
    localparam logic [15:0] C_NONE   = 16'b0000_0000_0000_0000;
    localparam logic [15:0] C_FRDY   = 16'b1001_0010_0000_0001;
    localparam logic [15:0] C_FWAIT  = 16'b0001_0000_0000_0001;
    localparam logic [15:0] C_DECODE = 16'b0000_0000_0000_0011;
    localparam logic [15:0] C_MEMADR = 16'b0000_0001_0000_0010;
    localparam logic [15:0] C_MEMRD  = 16'b0011_0000_0000_0000;
    localparam logic [15:0] C_MEMWB  = 16'b0000_0100_1000_0000;
    localparam logic [15:0] C_MEMWR  = 16'b0010_1000_0000_0000;
    localparam logic [15:0] C_EXEC   = 16'b0000_0001_0000_1000;
    localparam logic [15:0] C_RWB    = 16'b0000_0000_1100_0000;
    localparam logic [15:0] C_ADDIEX = 16'b0000_0001_0000_0010;
    localparam logic [15:0] C_ADDIWB = 16'b0000_0000_1000_0000;
    localparam logic [15:0] C_BRANCH = 16'b0100_0001_0001_0100;
    localparam logic [15:0] C_JUMP   = 16'b1000_0000_0010_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;

    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic        IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0]  PCSource, ALUOp, ALUSrcB;
    logic [3:0]  state;
    logic        halted, err;
    logic [15:0] instr_count;
    logic [15:0] obsCtrl;

    logic        p2PCWrite, p2PCWriteCond, p2IorD, p2MemRead, p2MemWrite, p2MemtoReg;
    logic        p2IRWrite, p2ALUSrcA, p2RegWrite, p2RegDst;
    logic [1:0]  p2PCSource, p2ALUOp, p2ALUSrcB;
    logic [3:0]  p2State;
    logic        p2Halted, p2Err;
    logic [1:0]  p2Count;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic        halted;
        logic        err;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    assign obsCtrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                      IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB};

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
        .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcB(ALUSrcB), .state(state), .halted(halted), .err(err),
        .instr_count(instr_count)
    );

    multicycle_ctrl #(.CNT_W(2)) dutSmall (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(p2PCWrite), .PCWriteCond(p2PCWriteCond), .IorD(p2IorD), .MemRead(p2MemRead),
        .MemWrite(p2MemWrite), .MemtoReg(p2MemtoReg), .IRWrite(p2IRWrite), .ALUSrcA(p2ALUSrcA),
        .RegWrite(p2RegWrite), .RegDst(p2RegDst), .PCSource(p2PCSource), .ALUOp(p2ALUOp),
        .ALUSrcB(p2ALUSrcB), .state(p2State), .halted(p2Halted), .err(p2Err),
        .instr_count(p2Count)
    );

    function automatic vec_t mkVec(input logic r, input logic [5:0] op, input logic mr,
                                   input logic [3:0] st, input logic [15:0] ctrl,
                                   input logic h, input logic e,
                                   input logic [15:0] cnt, input logic [1:0] cnt2);
        vec_t v;
        v.rst = r; v.op = op; v.mr = mr; v.st = st; v.ctrl = ctrl;
        v.halted = h; v.err = e; v.cnt = cnt; v.cnt2 = cnt2;
        return v;
    endfunction

    // Drive one cycle's inputs at the falling edge, then settle before sampling
    task automatic applyStimulus(input logic r, input logic [5:0] op, input logic mr);
        @(negedge clk);
        rst       = r;
        opcode    = op;
        mem_ready = mr;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] expSt,
                               input logic [15:0] expCtrl, input logic expH,
                               input logic expE, input logic [15:0] expCnt,
                               input logic [1:0] expCnt2);
        compared++;
        if ({state, obsCtrl, halted, err, instr_count, p2Count} !==
            {expSt, expCtrl, expH, expE, expCnt, expCnt2}) begin
            mismatched++;
            $display("[TB] FAIL %s: got state=%0d ctrl=%h halted=%b err=%b cnt=%0d cnt2=%0d, required state=%0d ctrl=%h halted=%b err=%b cnt=%0d cnt2=%0d",
                     name, state, obsCtrl, halted, err, instr_count, p2Count,
                     expSt, expCtrl, expH, expE, expCnt, expCnt2);
        end
    endtask

    initial begin
        // rst, opcode, mem_ready | state, ctrl, halted, err, count, small count
        vecs.push_back(mkVec(0, 6'b000000, 1,  0, C_NONE,   0, 0, 0, 0));
        vecs.push_back(mkVec(1, 6'b000000, 1,  0, C_FRDY,   0, 0, 0, 0));
        vecs.push_back(mkVec(1, 6'b000000, 1,  1, C_DECODE, 0, 0, 0, 0));
        vecs.push_back(mkVec(1, 6'b000000, 1,  6, C_EXEC,   0, 0, 0, 0));
        vecs.push_back(mkVec(1, 6'b000000, 1,  7, C_RWB,    0, 0, 0, 0));
        vecs.push_back(mkVec(1, 6'b000000, 1,  0, C_FRDY,   0, 0, 1, 1));
        vecs.push_back(mkVec(1, 6'b100011, 1,  1, C_DECODE, 0, 0, 1, 1));
        vecs.push_back(mkVec(1, 6'b000000, 0,  2, C_MEMADR, 0, 0, 1, 1));
        vecs.push_back(mkVec(1, 6'b000000, 0,  3, C_MEMRD,  0, 0, 1, 1));
        vecs.push_back(mkVec(1, 6'b000000, 0,  3, C_MEMRD,  0, 0, 1, 1));
        vecs.push_back(mkVec(1, 6'b000000, 0,  3, C_MEMRD,  0, 0, 1, 1));
        vecs.push_back(mkVec(1, 6'b000000, 1,  3, C_MEMRD,  0, 0, 1, 1));
        vecs.push_back(mkVec(1, 6'b000000, 1,  4, C_MEMWB,  0, 0, 1, 1));
        vecs.push_back(mkVec(1, 6'b000000, 1,  0, C_FRDY,   0, 0, 2, 2));
        vecs.push_back(mkVec(1, 6'b101011, 1,  1, C_DECODE, 0, 0, 2, 2));
        vecs.push_back(mkVec(1, 6'b000000, 1,  2, C_MEMADR, 0, 0, 2, 2));
        vecs.push_back(mkVec(1, 6'b000000, 1,  5, C_MEMWR,  0, 0, 2, 2));
        vecs.push_back(mkVec(1, 6'b000000, 1,  0, C_FRDY,   0, 0, 3, 3));
        vecs.push_back(mkVec(1, 6'b001000, 1,  1, C_DECODE, 0, 0, 3, 3));
        vecs.push_back(mkVec(1, 6'b000000, 1, 10, C_ADDIEX, 0, 0, 3, 3));
        vecs.push_back(mkVec(1, 6'b000000, 1, 11, C_ADDIWB, 0, 0, 3, 3));
        vecs.push_back(mkVec(1, 6'b000000, 1,  0, C_FRDY,   0, 0, 4, 3));
        vecs.push_back(mkVec(1, 6'b000100, 1,  1, C_DECODE, 0, 0, 4, 3));
        vecs.push_back(mkVec(1, 6'b000000, 1,  8, C_BRANCH, 0, 0, 4, 3));
        vecs.push_back(mkVec(1, 6'b000000, 1,  0, C_FRDY,   0, 0, 5, 3));
        vecs.push_back(mkVec(1, 6'b000010, 1,  1, C_DECODE, 0, 0, 5, 3));
        vecs.push_back(mkVec(1, 6'b000000, 1,  9, C_JUMP,   0, 0, 5, 3));
        vecs.push_back(mkVec(1, 6'b000000, 0,  0, C_FWAIT,  0, 0, 6, 3));
        vecs.push_back(mkVec(1, 6'b000000, 1,  0, C_FRDY,   0, 0, 6, 3));
        vecs.push_back(mkVec(1, 6'b111111, 1,  1, C_DECODE, 0, 0, 6, 3));
        vecs.push_back(mkVec(1, 6'b000000, 0, 12, C_NONE,   1, 0, 6, 3));
        vecs.push_back(mkVec(1, 6'b000000, 1, 12, C_NONE,   1, 0, 6, 3));
        vecs.push_back(mkVec(0, 6'b000000, 1, 12, C_NONE,   0, 0, 0, 0));
        vecs.push_back(mkVec(1, 6'b000000, 1,  0, C_FRDY,   0, 0, 0, 0));
        vecs.push_back(mkVec(1, 6'b010101, 1,  1, C_DECODE, 0, 0, 0, 0));
        vecs.push_back(mkVec(1, 6'b000000, 1, 13, C_NONE,   0, 1, 0, 0));
        vecs.push_back(mkVec(1, 6'b000000, 1, 13, C_NONE,   0, 1, 0, 0));
        vecs.push_back(mkVec(0, 6'b000000, 1, 13, C_NONE,   0, 0, 0, 0));
        vecs.push_back(mkVec(1, 6'b000000, 1,  0, C_FRDY,   0, 0, 0, 0));

        rst       = 1'b0;
        opcode    = 6'b000000;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].mr);
            checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctrl, vecs[i].halted,
                        vecs[i].err, vecs[i].cnt, vecs[i].cnt2);
        end

        // Fetch timeout: MAX_WAIT not-ready cycles are tolerated, one more errors out
        applyStimulus(0, 6'b000000, 0);
        applyStimulus(1, 6'b000000, 0);
        checkOutput("timeoutStart", 0, C_FWAIT, 0, 0, 0, 0);
        repeat (15) applyStimulus(1, 6'b000000, 0);
        checkOutput("timeoutEdge", 0, C_FWAIT, 0, 0, 0, 0);
        applyStimulus(1, 6'b000000, 0);
        checkOutput("timeoutError", 13, C_NONE, 0, 1, 0, 0);
        repeat (2) applyStimulus(1, 6'b000000, 1);
        checkOutput("errorSticky", 13, C_NONE, 0, 1, 0, 0);
        applyStimulus(0, 6'b000000, 1);
        checkOutput("errorResetMask", 13, C_NONE, 0, 0, 0, 0);
        applyStimulus(0, 6'b000000, 1);
        checkOutput("errorResetState", 0, C_NONE, 0, 0, 0, 0);

        // Reset asserted in the middle of a store's memory wait
        applyStimulus(1, 6'b000000, 1);
        checkOutput("seqFetch", 0, C_FRDY, 0, 0, 0, 0);
        repeat (3) applyStimulus(1, 6'b000000, 1);
        applyStimulus(1, 6'b000000, 1);
        checkOutput("seqRetire", 0, C_FRDY, 0, 0, 1, 1);
        applyStimulus(1, 6'b101011, 1);
        applyStimulus(1, 6'b000000, 1);
        applyStimulus(1, 6'b000000, 0);
        checkOutput("storeWait", 5, C_MEMWR, 0, 0, 1, 1);
        applyStimulus(1, 6'b000000, 0);
        applyStimulus(0, 6'b000000, 0);
        checkOutput("storeResetMask", 5, C_NONE, 0, 0, 0, 0);
        applyStimulus(1, 6'b000000, 1);
        checkOutput("storeResetFetch", 0, C_FRDY, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, max consecutive not-ready cycles tolerated in a memory wait state.
REQ-002 SHALL have parameter CNT_W, default 16, width of retired-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 opcode  input  6  IR[31:26]; sampled only in DECODE.
REQ-006 mem_ready  input  1  memory access complete this cycle.
REQ-007 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls.
REQ-008 PCSource, ALUOp, ALUSrcB  output  2 each  datapath selects.
REQ-009 state  output  4  current FSM state code; halted  output  1; err  output  1; instr_count  output  CNT_W.

Function
REQ-010 SHALL be a Moore FSM with codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, HALT=12, ERROR=13; codes 14-15 SHALL go to ERROR next cycle.
REQ-011 Unlisted outputs in a state SHALL be 0.
REQ-012 FETCH: MemRead=1, ALUSrcB=01, ALUOp=00, PCSource=00; PCWrite=IRWrite=mem_ready; stay while mem_ready=0, else -> DECODE.
REQ-013 DECODE: ALUSrcB=11, ALUOp=00; next by opcode: 000000->EXEC, 001000->ADDIEX, 100011/101011->MEMADR, 000100->BRANCH, 000010->JUMP, 111111->HALT, any other->ERROR.
REQ-014 MEMADR: ALUSrcA=1, ALUSrcB=10; -> MEMRD if latched opcode 100011, -> MEMWR if 101011 (opcode latched in DECODE into internal register).
REQ-015 MEMRD: MemRead=1, IorD=1; stay while mem_ready=0, else -> MEMWB.
REQ-016 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; -> FETCH.
REQ-017 MEMWR: MemWrite=1, IorD=1; stay while mem_ready=0, else -> FETCH.
REQ-018 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; -> RWB. RWB: RegWrite=1, RegDst=1; -> FETCH.
REQ-019 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; -> ADDIWB. ADDIWB: RegWrite=1, RegDst=0; -> FETCH.
REQ-020 BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01; -> FETCH.
REQ-021 JUMP: PCWrite=1, PCSource=10; -> FETCH.
REQ-022 HALT: halted=1, all datapath controls 0; absorbing until reset.
REQ-023 ERROR: err=1, all datapath controls 0; absorbing until reset.
REQ-024 Cycle counts: R-type/addi/lw-store path: R=4, addi=4, lw=5, sw=4, beq=3, j=3 cycles with mem_ready always 1; each mem_ready=0 cycle adds one.
REQ-025 Wait counter SHALL clear on entry to FETCH/MEMRD/MEMWR and whenever mem_ready=1; increments each cycle in those states with mem_ready=0; when it equals MAX_WAIT with mem_ready still 0 the next state SHALL be ERROR (MAX_WAIT+1 not-ready cycles -> ERROR).
REQ-026 instr_count SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR, RWB, ADDIWB, BRANCH, JUMP; saturates at all-ones; HALT entry does not count.
REQ-027 mem_ready is ignored outside FETCH/MEMRD/MEMWR; opcode ignored outside DECODE.

Reset
REQ-028 On rising clk with rst=0: state=FETCH, wait counter=0, latched opcode=0, instr_count=0, halted=0, err=0, regardless of current state including HALT/ERROR or mid-wait.
REQ-029 While rst=0, every output other than state SHALL be 0 (combinational mask); first FETCH outputs appear in the first cycle with rst=1.

Verification
REQ-030 Reset then opcode=000000, mem_ready=1 -> states 0,1,6,7,0; RegWrite=1, RegDst=1 only in RWB; instr_count=1.
REQ-031 lw (100011) with mem_ready=0 for 3 cycles in MEMRD -> MEMRD held 4 cycles, MemRead=IorD=1 throughout, then MEMWB with MemtoReg=1; total 8 cycles.
REQ-032 FETCH with mem_ready held 0 for 16 cycles, MAX_WAIT=15 -> state=13, err=1, all controls 0; stays until rst=0.
REQ-033 opcode=111111 -> HALT after DECODE, halted=1, instr_count unchanged; rst=0 one cycle -> state=0, halted=0.
REQ-034 opcode=010101 -> ERROR; beq -> PCWriteCond=1, PCSource=01 one cycle; j -> PCWrite=1, PCSource=10 one cycle.
REQ-035 rst=0 asserted mid-MEMWR wait -> next state FETCH, MemWrite=0 during reset cycle, instr_count=0; CNT_W=2 with 5 retired instrs -> instr_count=3.
